// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, single-cycle logic/arith ops plus shift-add MUL when ALU_MC_MUL_EN is defined
module alu_mc #(
    parameter int WORD = 16,
    parameter int OPW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  alu_op,
    input  logic [WORD-1:0] A,
    input  logic [WORD-1:0] bus,
    output logic [WORD-1:0] G,
    output logic [WORD-1:0] GH,
    output logic            busy,
    output logic            done,
    output logic [3:0]      flags
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
`ifdef ALU_MC_MUL_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'(7);
    localparam int CW = $clog2(WORD);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    logic [2*WORD-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD:0]     step;
`else
    typedef enum logic {IDLE, EXEC} state_t;
`endif
    state_t            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [WORD-1:0]   a_q, a_d, b_q, b_d;
    logic [WORD-1:0]   g_q, g_d, gh_q, gh_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic [WORD:0]     sum, dif;
    logic [WORD-1:0]   res;
    logic              c, v, upd;

    // state register; reset wins over any pending start
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state: start only matters in IDLE, MUL runs WORD cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ALU_MC_MUL_EN
                if (start) state_d = (alu_op == OP_MUL) ? MUL : EXEC;
`else
                if (start) state_d = EXEC;
`endif
            end
            EXEC: state_d = IDLE;
`ifdef ALU_MC_MUL_EN
            MUL: state_d = (cnt_q == CW'(WORD - 1)) ? IDLE : MUL;
`endif
            default: state_d = IDLE;
        endcase
    end

    // outputs: busy follows the state, result registers drive the rest
    always_comb begin
        busy  = state_q != IDLE;
        done  = done_q;
        G     = g_q;
        GH    = gh_q;
        flags = flags_q;
    end

    // single-cycle ALU on captured operands; upd=0 means hold results (NOP and unsupported ops)
    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        dif = {1'b0, a_q} - {1'b0, b_q};
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        upd = 1'b0;
        case (op_q)
            OP_ADD: begin
                res = sum[WORD-1:0];
                c   = sum[WORD];
                v   = (a_q[WORD-1] == b_q[WORD-1]) && (sum[WORD-1] != a_q[WORD-1]);
                upd = 1'b1;
            end
            OP_SUB: begin
                res = dif[WORD-1:0];
                c   = dif[WORD];
                v   = (a_q[WORD-1] != b_q[WORD-1]) && (dif[WORD-1] != a_q[WORD-1]);
                upd = 1'b1;
            end
            OP_AND: begin
                res = a_q & b_q;
                upd = 1'b1;
            end
            OP_OR: begin
                res = a_q | b_q;
                upd = 1'b1;
            end
            OP_XOR: begin
                res = a_q ^ b_q;
                upd = 1'b1;
            end
            OP_SHL: begin
                res = {a_q[WORD-2:0], 1'b0};
                c   = a_q[WORD-1];
                upd = 1'b1;
            end
            default: ;
        endcase
    end

    // datapath next-state: capture on accept, write results on the finishing cycle
    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        gh_d    = gh_q;
        flags_d = flags_q;
        done_d  = 1'b0;
`ifdef ALU_MC_MUL_EN
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        step    = {1'b0, prod_q[2*WORD-1:WORD]} + (prod_q[0] ? {1'b0, a_q} : '0);
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = alu_op;
                    a_d  = A;
                    b_d  = bus;
`ifdef ALU_MC_MUL_EN
                    prod_d = {{WORD{1'b0}}, bus};
                    cnt_d  = '0;
`endif
                end
            end
            EXEC: begin
                done_d = 1'b1;
                if (upd) begin
                    g_d     = res;
                    gh_d    = '0;
                    flags_d = {res == '0, res[WORD-1], c, v};
                end
            end
`ifdef ALU_MC_MUL_EN
            MUL: begin
                prod_d = {step, prod_q[WORD-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WORD - 1)) begin
                    done_d  = 1'b1;
                    g_d     = prod_d[WORD-1:0];
                    gh_d    = prod_d[2*WORD-1:WORD];
                    flags_d = {prod_d == '0, prod_d[2*WORD-1], |prod_d[2*WORD-1:WORD], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    // datapath registers; reset clears results and suppresses done of an aborted op
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            gh_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
`ifdef ALU_MC_MUL_EN
            prod_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            gh_q    <= gh_d;
            flags_q <= flags_d;
            done_q  <= done_d;
`ifdef ALU_MC_MUL_EN
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc (WORD=16), MUL checks follow ALU_MC_MUL_EN
module tb_alu_mc;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]  alu_op = '0;
    logic [15:0] A = '0, bus = '0, G, GH;
    logic        busy, done;
    logic [3:0]  flags;
    int          total = 0, passed = 0;
`ifdef ALU_MC_MUL_EN
    localparam int RN = 8;
`else
    localparam int RN = 1;
`endif

    alu_mc #(.WORD(16)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .A(A), .bus(bus),
        .G(G), .GH(GH), .busy(busy), .done(done), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int exp_lat, input string tag);
        int lat = 0;
        @(negedge clk);
        start = 1'b1; alu_op = op; A = a; bus = b;
        @(posedge clk); #1;
        start = 1'b0; alu_op = 3'd2; A = 16'hDEAD; bus = 16'hBEEF;
        chk({tag, "_busy"}, busy, 1);
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 100);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, dn;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_G", G, 0);
        chk("rst_GH", GH, 0);
        chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;

        run(3'd1, 16'h0001, 16'h000E, 1, "add1");
        chk("add1_G", G, 16'h000F); chk("add1_GH", GH, 0); chk("add1_flags", flags, 4'b0000);
        run(3'd0, 16'h1234, 16'h5678, 1, "nop");
        chk("nop_G", G, 16'h000F); chk("nop_flags", flags, 4'b0000);
        @(posedge clk); #1;
        chk("nop_single_done", done, 0);

        run(3'd2, 16'h000F, 16'h000E, 1, "sub1");
        chk("sub1_G", G, 16'h0001); chk("sub1_flags", flags, 4'b0000);
        run(3'd2, 16'h0001, 16'h000E, 1, "sub2");
        chk("sub2_G", G, 16'hFFF3); chk("sub2_flags", flags, 4'b0110);
        run(3'd1, 16'h7FFF, 16'h0001, 1, "addv");
        chk("addv_G", G, 16'h8000); chk("addv_flags", flags, 4'b0101);
        run(3'd1, 16'hFFFF, 16'h0001, 1, "addc");
        chk("addc_G", G, 16'h0000); chk("addc_flags", flags, 4'b1010);
        run(3'd3, 16'hF0F0, 16'h0FF0, 1, "and");
        chk("and_G", G, 16'h00F0); chk("and_flags", flags, 4'b0000);
        run(3'd4, 16'h8000, 16'h0001, 1, "or");
        chk("or_G", G, 16'h8001); chk("or_flags", flags, 4'b0100);
        run(3'd5, 16'hAAAA, 16'hAAAA, 1, "xor");
        chk("xor_G", G, 16'h0000); chk("xor_flags", flags, 4'b1000);
        run(3'd6, 16'h8001, 16'h0000, 1, "shl");
        chk("shl_G", G, 16'h0002); chk("shl_GH", GH, 0); chk("shl_flags", flags, 4'b0010);

`ifdef ALU_MC_MUL_EN
        @(negedge clk);
        start = 1'b1; alu_op = 3'd7; A = 16'h1234; bus = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0; A = 16'hFFFF; bus = 16'hFFFF;
        chk("mul_busy", busy, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin start = 1'b1; alu_op = 3'd1; end
            if (lat == 6) start = 1'b0;
            if (lat == 8) begin chk("mul_G_held", G, 16'h0002); chk("mul_GH_held", GH, 0); end
        end while (!done && lat < 100);
        chk("mul_lat", lat, 16);
        chk("mul_busy_at_done", busy, 0);
        chk("mul_G", G, 16'h3400); chk("mul_GH", GH, 16'h0012); chk("mul_flags", flags, 4'b0010);
        @(posedge clk); #1;
        chk("mul_no_queued_done", done, 0);
        chk("mul_no_queued_busy", busy, 0);
`else
        run(3'd7, 16'h1234, 16'h0100, 1, "op7");
        chk("op7_G", G, 16'h0002); chk("op7_GH", GH, 0); chk("op7_flags", flags, 4'b0010);
`endif

        @(negedge clk);
        start = 1'b1; alu_op = 3'd1; A = 16'h0003; bus = 16'h0004;
        @(posedge clk); #1;
        alu_op = 3'd4; A = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_G", G, 16'h0007);
        @(posedge clk); #1;
        chk("ign_no_done", done, 0);
        chk("ign_no_busy", busy, 0);

        @(negedge clk);
`ifdef ALU_MC_MUL_EN
        alu_op = 3'd7;
`else
        alu_op = 3'd1;
`endif
        start = 1'b1; A = 16'h0005; bus = 16'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (RN - 1) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; alu_op = 3'd1;
        @(posedge clk); #1;
        chk("abort_G", G, 0); chk("abort_GH", GH, 0); chk("abort_flags", flags, 0);
        chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        rst = 1'b0; start = 1'b0;
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
